// File: rtl/hazard_controller.sv
// Decode-side hazard controller: RAW scoreboard stall, branch flush bubbles, halt drain, counters.
// Optional build macro HAZARD_FWD_EN: EX/MEM forwarding, only load-use stalls remain.
module hazard_controller #(
   parameter int PIPE_DEPTH     = 3,
   parameter int BRANCH_PENALTY = 1,
   parameter int CNT_W          = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_dec_valid,
   input  logic [4:0]       i_dec_rs1,
   input  logic [4:0]       i_dec_rs2,
   input  logic             i_dec_uses_rs2,
   input  logic [4:0]       i_dec_rd,
   input  logic             i_dec_reg_wren,
   input  logic             i_dec_is_load,
   input  logic             i_dec_redirect,
   input  logic             i_dec_halt,
   output logic             o_stall,
   output logic             o_flush,
   output logic             o_issue,
   output logic             o_pipe_empty,
   output logic             o_halted,
   output logic [CNT_W-1:0] o_cycle_count,
   output logic [CNT_W-1:0] o_stall_count
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   localparam int FC_W = (BRANCH_PENALTY > 2) ? $clog2(BRANCH_PENALTY) : 1;
   localparam logic [FC_W-1:0] FC_LOAD = (BRANCH_PENALTY > 0) ? FC_W'(BRANCH_PENALTY - 1) : '0;
   localparam logic FLUSH_EN = (BRANCH_PENALTY > 0);

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic [FC_W-1:0]             r_fcnt;
   logic [FC_W-1:0]             w_fcnt_nxt;
   logic [PIPE_DEPTH-1:0]       r_sb_valid;
   logic [PIPE_DEPTH-1:0][4:0]  r_sb_rd;
   logic [PIPE_DEPTH-1:0]       r_sb_load;
   logic [CNT_W-1:0]            r_cycle_count;
   logic [CNT_W-1:0]            r_stall_count;
   logic                        w_hazard;
   logic                        w_run;
   logic                        w_stall;
   logic                        w_issue;
   logic                        w_new_valid;
   logic                        w_pipe_empty;
   logic                        w_unused;

   function automatic logic f_src_hit(input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic uses_rs2, input logic [4:0] rd);
      return ((rs1 != 5'd0) && (rs1 == rd)) || (uses_rs2 && (rs2 != 5'd0) && (rs2 == rd));
   endfunction

   // The writeback slot is never compared (the regfile writes through), so its tag is only a drop-out.
   always_comb begin
      w_hazard = 1'b0;
`ifdef HAZARD_FWD_EN
      w_hazard = r_sb_valid[0] & r_sb_load[0]
               & f_src_hit(i_dec_rs1, i_dec_rs2, i_dec_uses_rs2, r_sb_rd[0]);
`else
      for (int k = 0; k < PIPE_DEPTH - 1; k++) begin
         w_hazard = w_hazard | (r_sb_valid[k]
                  & f_src_hit(i_dec_rs1, i_dec_rs2, i_dec_uses_rs2, r_sb_rd[k]));
      end
`endif
   end

   assign w_run        = (r_state == ST_RUN);
   assign w_stall      = i_dec_valid & w_run & w_hazard;
   assign w_issue      = i_dec_valid & w_run & ~w_hazard;
   assign w_new_valid  = w_issue & i_dec_reg_wren & (i_dec_rd != 5'd0);
   assign w_pipe_empty = ~|r_sb_valid;
   assign w_unused     = r_sb_load[PIPE_DEPTH-1] ^ (^r_sb_rd[PIPE_DEPTH-1]);

   // Next-state logic; halt takes priority over a redirect issued in the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_fcnt_nxt  = r_fcnt;
      case (r_state)
         ST_RUN: begin
            if (w_issue && i_dec_halt) begin
               w_state_nxt = ST_DRAIN;
            end else if (w_issue && i_dec_redirect && FLUSH_EN) begin
               w_state_nxt = ST_FLUSH;
               w_fcnt_nxt  = FC_LOAD;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_FLUSH: begin
            if (r_fcnt == '0) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_fcnt_nxt = r_fcnt - FC_W'(1);
            end
         end
         ST_DRAIN: begin
            if (w_pipe_empty) begin
               w_state_nxt = ST_HALTED;
            end else begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_HALTED: w_state_nxt = ST_HALTED;
         default:   w_state_nxt = ST_RUN;
      endcase
   end

   // FSM state and flush counter.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_RUN;
         r_fcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_fcnt  <= w_fcnt_nxt;
      end
   end

   // Scoreboard shift: bubbles enter whenever nothing that writes a register issues.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sb_valid <= '0;
         r_sb_rd    <= '0;
         r_sb_load  <= '0;
      end else begin
         r_sb_valid <= {r_sb_valid[PIPE_DEPTH-2:0], w_new_valid};
         r_sb_rd    <= {r_sb_rd[PIPE_DEPTH-2:0], i_dec_rd};
         r_sb_load  <= {r_sb_load[PIPE_DEPTH-2:0], i_dec_is_load};
      end
   end

   // Free-running counters, wrapping naturally at 2^CNT_W.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cycle_count <= '0;
         r_stall_count <= '0;
      end else begin
         if (r_state != ST_HALTED) begin
            r_cycle_count <= r_cycle_count + CNT_W'(1);
         end
         if (w_stall) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
         end
      end
   end

   assign o_stall       = w_stall;
   assign o_issue       = w_issue;
   assign o_flush       = (r_state != ST_RUN);
   assign o_halted      = (r_state == ST_HALTED);
   assign o_pipe_empty  = w_pipe_empty;
   assign o_cycle_count = r_cycle_count;
   assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus randomized traffic
// compared against a timestamp-based reference model of in-flight writes.
module tb_hazard_controller;
   localparam int PD = 3;
   localparam int BP = 1;
   localparam int CW = 32;

   logic clk = 1'b0;
   logic rst, dec_valid, dec_uses_rs2, dec_reg_wren, dec_is_load, dec_redirect, dec_halt;
   logic [4:0] dec_rs1, dec_rs2, dec_rd;
   logic stall, flush, issue, pipe_empty, halted;
   logic [CW-1:0] cycle_count, stall_count;

   int checks = 0;
   int errors = 0;

   hazard_controller #(.PIPE_DEPTH(PD), .BRANCH_PENALTY(BP), .CNT_W(CW)) dut (
      .i_clk(clk), .i_rst(rst), .i_dec_valid(dec_valid), .i_dec_rs1(dec_rs1),
      .i_dec_rs2(dec_rs2), .i_dec_uses_rs2(dec_uses_rs2), .i_dec_rd(dec_rd),
      .i_dec_reg_wren(dec_reg_wren), .i_dec_is_load(dec_is_load),
      .i_dec_redirect(dec_redirect), .i_dec_halt(dec_halt),
      .o_stall(stall), .o_flush(flush), .o_issue(issue), .o_pipe_empty(pipe_empty),
      .o_halted(halted), .o_cycle_count(cycle_count), .o_stall_count(stall_count));

   always #5 clk = ~clk;

   // Reference model: each register write is remembered with the cycle it issued in.
   typedef struct { int t; logic [4:0] rd; bit ld; } wr_t;
   wr_t m_q[$];
   int m_now = 0;
   int m_mode = 0;   // 0 run, 1 flush, 2 drain, 3 halted
   int m_fcnt = 0;
   logic [CW-1:0] m_cyc = '0;
   logic [CW-1:0] m_stl = '0;
   bit m_haz, m_empty, m_stall, m_issue;
   logic [4:0] m_flags;  // {stall, issue, flush, pipe_empty, halted}

   task automatic settle();
      #1;
      m_haz = 1'b0;
      m_empty = 1'b1;
      foreach (m_q[i]) begin
         int age;
         bit hit;
         age = m_now - m_q[i].t;
         if (age >= 1 && age <= PD) m_empty = 1'b0;
         hit = (dec_rs1 != 5'd0 && dec_rs1 == m_q[i].rd) ||
               (dec_uses_rs2 && dec_rs2 != 5'd0 && dec_rs2 == m_q[i].rd);
`ifdef HAZARD_FWD_EN
         if (age == 1 && m_q[i].ld && hit) m_haz = 1'b1;
`else
         if (age >= 1 && age <= PD - 1 && hit) m_haz = 1'b1;
`endif
      end
      m_stall = dec_valid && m_mode == 0 && m_haz;
      m_issue = dec_valid && m_mode == 0 && !m_haz;
      m_flags = {m_stall, m_issue, m_mode != 0, m_empty, m_mode == 3};
   endtask

   task automatic tick();
      settle();
      @(posedge clk);
      if (rst) begin
         m_q.delete();
         m_mode = 0; m_fcnt = 0; m_cyc = '0; m_stl = '0;
      end else begin
         if (m_mode != 3) m_cyc = m_cyc + 1;
         if (m_stall) m_stl = m_stl + 1;
         if (m_issue && dec_reg_wren && dec_rd != 5'd0) m_q.push_back('{m_now, dec_rd, dec_is_load});
         case (m_mode)
            0: if (m_issue && dec_halt) m_mode = 2;
               else if (m_issue && dec_redirect && BP > 0) begin m_mode = 1; m_fcnt = BP - 1; end
            1: if (m_fcnt == 0) m_mode = 0; else m_fcnt--;
            2: if (m_empty) m_mode = 3;
            default: ;
         endcase
      end
      m_now++;
      while (m_q.size() > 0 && m_now - m_q[0].t > PD) void'(m_q.pop_front());
      @(negedge clk);
   endtask

   task automatic set_in(input bit v, input logic [4:0] rs1, input logic [4:0] rs2, input bit u2,
                         input logic [4:0] rd, input bit wr, input bit ld, input bit rdr, input bit hlt);
      dec_valid = v; dec_rs1 = rs1; dec_rs2 = rs2; dec_uses_rs2 = u2; dec_rd = rd;
      dec_reg_wren = wr; dec_is_load = ld; dec_redirect = rdr; dec_halt = hlt;
   endtask

   task automatic idle(input int n);
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
   endtask

   task automatic count_stalls(output int n);
      n = 0;
      settle();
      while (stall === 1'b1 && n < 8) begin
         n++;
         tick();
         settle();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle(2);
      settle();
      checks++;
      if ({stall, issue, flush, pipe_empty, halted} !== 5'b00010) begin
         errors++; $display("FAIL reset_flags: got %b expected %b", {stall, issue, flush, pipe_empty, halted}, 5'b00010);
      end
      checks++;
      if (cycle_count !== 32'd0 || stall_count !== 32'd0) begin
         errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", cycle_count, stall_count);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (cycle_count !== 32'd1) begin
         errors++; $display("FAIL first_cycle: got %0d expected 1", cycle_count);
      end
   endtask

   task automatic test_raw_stall();
      int n, exp_n;
`ifdef HAZARD_FWD_EN
      exp_n = 0;
`else
      exp_n = PD - 1;
`endif
      do_reset();
      set_in(1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 5'd5, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      count_stalls(n);
      checks++;
      if (n !== exp_n || issue !== 1'b1) begin
         errors++; $display("FAIL raw_stall: got stalls=%0d issue=%b expected stalls=%0d issue=1", n, issue, exp_n);
      end
      checks++;
      if (stall_count !== 32'(exp_n)) begin
         errors++; $display("FAIL raw_stall_count: got %0d expected %0d", stall_count, exp_n);
      end
      tick();
   endtask

   task automatic test_load_use();
      int n, exp_n;
`ifdef HAZARD_FWD_EN
      exp_n = 1;
`else
      exp_n = PD - 1;
`endif
      do_reset();
      set_in(1'b1, 5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 5'd0, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      count_stalls(n);
      checks++;
      if (n !== exp_n) begin
         errors++; $display("FAIL load_use_rs2: got %0d stalls expected %0d", n, exp_n);
      end
      idle(PD + 1);
      set_in(1'b1, 5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 5'd0, 5'd7, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      count_stalls(n);
      checks++;
      if (n !== 0) begin
         errors++; $display("FAIL load_rs2_unused: got %0d stalls expected 0", n);
      end
      idle(PD + 1);
      set_in(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 5'd0, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      count_stalls(n);
      checks++;
      if (n !== 0) begin
         errors++; $display("FAIL x0_no_hazard: got %0d stalls expected 0", n);
      end
      tick();
   endtask

   task automatic test_redirect();
      int n;
      do_reset();
      set_in(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      set_in(1'b1, 5'd3, 5'd4, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
      settle();
      checks++;
      if ({flush, issue, stall} !== 3'b100) begin
         errors++; $display("FAIL redirect_flush: got %b expected %b", {flush, issue, stall}, 3'b100);
      end
      tick();
      settle();
      checks++;
      if ({flush, issue} !== 2'b01) begin
         errors++; $display("FAIL redirect_resume: got %b expected %b", {flush, issue}, 2'b01);
      end
      tick();
      idle(PD);
      set_in(1'b1, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      settle();
      checks++;
      if (flush !== 1'b0) begin
         errors++; $display("FAIL stalled_redirect_noflush: got flush=%b expected 0", flush);
      end
      count_stalls(n);
      tick();
      settle();
      checks++;
      if (flush !== 1'b1) begin
         errors++; $display("FAIL stalled_redirect_flush: got flush=%b expected 1 after %0d stalls", flush, n);
      end
      tick();
   endtask

   task automatic test_halt();
      int n;
      do_reset();
      set_in(1'b1, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 5'd0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      set_in(1'b1, 5'd1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      settle();
      checks++;
      if ({stall, issue, flush, pipe_empty, halted} !== 5'b00100) begin
         errors++; $display("FAIL drain_flags: got %b expected %b", {stall, issue, flush, pipe_empty, halted}, 5'b00100);
      end
      n = 0;
      while (halted !== 1'b1 && n < 10) begin
         n++;
         tick();
         settle();
      end
      // Last write issued one cycle before the halt, so it leaves the pipe PD cycles after drain starts.
      checks++;
      if (n !== PD) begin
         errors++; $display("FAIL drain_length: got %0d cycles expected %0d", n, PD);
      end
      repeat (3) tick();
      settle();
      checks++;
      if (cycle_count !== m_cyc || halted !== 1'b1 || flush !== 1'b1) begin
         errors++; $display("FAIL halted_frozen: got cnt=%0d halted=%b expected cnt=%0d halted=1", cycle_count, halted, m_cyc);
      end
      do_reset();
      set_in(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      idle(1);
      settle();
      checks++;
      if ({flush, halted} !== 2'b11) begin
         errors++; $display("FAIL halt_over_redirect: got %b expected %b", {flush, halted}, 2'b11);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_in(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      settle();
      checks++;
      if ({stall, issue, flush, pipe_empty, halted} !== 5'b00010 || cycle_count !== 32'd0 || stall_count !== 32'd0) begin
         errors++; $display("FAIL reset_in_flush: got %b cnt=%0d/%0d expected 00010 cnt=0/0",
                            {stall, issue, flush, pipe_empty, halted}, cycle_count, stall_count);
      end
      set_in(1'b1, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      settle();
      checks++;
      if ({flush, pipe_empty, halted} !== 3'b100) begin
         errors++; $display("FAIL drain_entry: got %b expected %b", {flush, pipe_empty, halted}, 3'b100);
      end
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      settle();
      checks++;
      if ({stall, issue, flush, pipe_empty, halted} !== 5'b00010 || cycle_count !== 32'd0 || stall_count !== 32'd0) begin
         errors++; $display("FAIL reset_in_drain: got %b cnt=%0d/%0d expected 00010 cnt=0/0",
                            {stall, issue, flush, pipe_empty, halted}, cycle_count, stall_count);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         set_in(1'b1, 5'd1, 5'd2, 1'b1, 5'(10 + i), 1'b1, i[0], 1'b0, 1'b0);
         settle();
         checks++;
         if (issue !== 1'b1 || stall !== 1'b0) begin
            errors++; $display("FAIL back_to_back[%0d]: got issue=%b stall=%b expected 1/0", i, issue, stall);
         end
         tick();
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         rst = (m_mode == 3) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
         set_in($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0);
         settle();
         checks++;
         if ({stall, issue, flush, pipe_empty, halted} !== m_flags) begin
            errors++; $display("FAIL rand_flags[%0d]: got %b expected %b", i, {stall, issue, flush, pipe_empty, halted}, m_flags);
         end
         checks++;
         if (cycle_count !== m_cyc || stall_count !== m_stl) begin
            errors++; $display("FAIL rand_counts[%0d]: got %0d/%0d expected %0d/%0d", i, cycle_count, stall_count, m_cyc, m_stl);
         end
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_raw_stall();
      test_load_use();
      test_redirect();
      test_halt();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
